// File: rtl/e3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : e3_pkg
//  Description : Shared Excess-3 constants, FSM state encoding and a digit
//                validity helper for the sequential Excess-3 multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package e3_pkg;

    localparam int         E3_OFFSET = 3;
    localparam logic [3:0] E3_MIN    = 4'b0011;
    localparam logic [3:0] E3_MAX    = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } e3_state_e;

    // True when the nibble encodes a decimal digit 0..9 in Excess-3
    function automatic logic e3_digit_ok(input logic [3:0] d);
        return (d >= E3_MIN) && (d <= E3_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/e3_digit_mac.sv
`default_nettype none
// ============================================================================
//  Module      : e3_digit_mac
//  Description : One-digit BCD multiply-accumulate:
//                t = a*b + addend + carry_in, sum = t mod 10, carry = t div 10.
//                Inputs are BCD digits, so t never exceeds 99.
//  Revision    : 1.0 - initial release
// ============================================================================
module e3_digit_mac (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] addend,
    input  logic [3:0] carry_in,
    output logic [3:0] sum,
    output logic [3:0] carry_out
);

    logic [6:0] w_t;

    // Full-precision product-sum, then split into decimal digit and carry
    always_comb begin
        w_t       = 7'(a) * 7'(b) + 7'(addend) + 7'(carry_in);
        sum       = 4'(w_t % 7'd10);
        carry_out = 4'(w_t / 7'd10);
    end

endmodule
`default_nettype wire

// File: rtl/e3_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module      : e3_seq_mult
//  Description : Sequential Excess-3 multiplier. Operands are converted to
//                BCD on capture; one digit pair is processed per cycle into
//                a 2*DIGITS BCD accumulator, then re-encoded as Excess-3.
//  Revision    : 1.0 - initial release
// ============================================================================
module e3_seq_mult
    import e3_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   in_0,
    input  logic [4*DIGITS-1:0]   in_1,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [8*DIGITS-1:0]   out
);

    localparam int                 CW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int                 NACC      = 2 * DIGITS;
    localparam int                 PW        = $clog2(NACC);
    localparam logic [CW-1:0]      C_LAST    = CW'(DIGITS - 1);
    localparam logic [8*DIGITS-1:0] C_OUT_RST = {NACC{E3_MIN}};

    e3_state_e           state_q, state_d;
    logic [3:0]          a_q   [DIGITS];
    logic [3:0]          a_d   [DIGITS];
    logic [3:0]          b_q   [DIGITS];
    logic [3:0]          b_d   [DIGITS];
    logic [3:0]          acc_q [NACC];
    logic [3:0]          acc_d [NACC];
    logic [3:0]          carry_q, carry_d;
    logic [CW-1:0]       i_q, i_d, j_q, j_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [8*DIGITS-1:0] out_q, out_d;

    logic                w_in_ok;
    logic [PW-1:0]       w_pos, w_pos_hi;
    logic [3:0]          w_a_dig, w_b_dig, w_addend, w_carry_in;
    logic [3:0]          w_sum, w_carry_out;

    // Request is valid only when every nibble of both operands is a legal digit
    always_comb begin
        w_in_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!e3_digit_ok(in_0[4*k +: 4]) || !e3_digit_ok(in_1[4*k +: 4]))
                w_in_ok = 1'b0;
        end
    end

    // Select the current digit pair and the accumulator digit it lands on
    always_comb begin
        w_pos      = PW'(i_q) + PW'(j_q);
        w_pos_hi   = w_pos + 1'b1;
        w_a_dig    = 4'd0;
        w_b_dig    = 4'd0;
        w_addend   = 4'd0;
        w_carry_in = (i_q == '0) ? 4'd0 : carry_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (i_q == CW'(k)) w_a_dig = a_q[k];
            if (j_q == CW'(k)) w_b_dig = b_q[k];
        end
        for (int k = 0; k < NACC; k++) begin
            if (w_pos == PW'(k)) w_addend = acc_q[k];
        end
    end

    e3_digit_mac u_mac (
        .a         (w_a_dig),
        .b         (w_b_dig),
        .addend    (w_addend),
        .carry_in  (w_carry_in),
        .sum       (w_sum),
        .carry_out (w_carry_out)
    );

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        i_d     = i_q;
        j_d     = j_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (w_in_ok) begin
                        for (int k = 0; k < DIGITS; k++) begin
                            a_d[k] = in_0[4*k +: 4] - 4'(E3_OFFSET);
                            b_d[k] = in_1[4*k +: 4] - 4'(E3_OFFSET);
                        end
                        for (int k = 0; k < NACC; k++) acc_d[k] = 4'd0;
                        carry_d = 4'd0;
                        i_d     = '0;
                        j_d     = '0;
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end else begin
                        err_d   = 1'b1;
                        out_d   = C_OUT_RST;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                for (int k = 0; k < NACC; k++) begin
                    if (w_pos == PW'(k))
                        acc_d[k] = w_sum;
                    // The last digit of a row also deposits its carry one place up
                    if ((i_q == C_LAST) && (w_pos_hi == PW'(k)))
                        acc_d[k] = w_carry_out;
                end
                carry_d = w_carry_out;
                if (i_q == C_LAST) begin
                    i_d = '0;
                    if (j_q == C_LAST) begin
                        j_d     = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                        state_d = DONE;
                        for (int k = 0; k < NACC; k++)
                            out_d[4*k +: 4] = acc_d[k] + 4'(E3_OFFSET);
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any operation silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '{default: 4'd0};
            b_q     <= '{default: 4'd0};
            acc_q   <= '{default: 4'd0};
            carry_q <= 4'd0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            out_q   <= C_OUT_RST;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            i_q     <= i_d;
            j_q     <= j_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            out_q   <= out_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign out  = out_q;

endmodule
`default_nettype wire
